// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider, its control stage and the register file.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam int unsigned MIN_RATIO = 2;

endpackage

// File: rtl/clk_phase_ctr.sv
// Shadow phase counter; steps in lockstep with the divider's internal counter.
module clk_phase_ctr #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_ratio,
  output logic             o_bnd_c
);

  logic [WIDTH-1:0] r_phase;

  assign o_bnd_c = i_en && (r_phase == (i_ratio - WIDTH'(1)));

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_phase <= '0;
    end else if (i_en) begin
      r_phase <= o_bnd_c ? '0 : (r_phase + WIDTH'(1));
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider control: boundary-aligned ratio commits and glitch-free start/stop.
// Optional o_period_tick output when CLK_DIV_CTRL_TICK_EN is defined.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned DEFAULT_RATIO = 2
) (
  input  logic             i_ref_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_cfg_ratio,
  input  logic             i_cfg_valid,
  output logic [WIDTH-1:0] o_div_ratio,
  output logic             o_clk_en,
  output logic             o_cfg_ack,
  output logic             o_cfg_err,
  output logic             o_busy
`ifdef CLK_DIV_CTRL_TICK_EN
  ,
  output logic             o_period_tick
`endif
);

  state_t           r_state;
  logic [WIDTH-1:0] r_div_ratio;
  logic [WIDTH-1:0] r_pend_ratio;
  logic             r_pend_vld;
  logic             r_clk_en;
  logic             r_cfg_ack;
  logic             r_cfg_err;
  logic             w_bnd;
  logic             w_wr_ok;
  logic             w_wr_bad;

  assign w_wr_bad = i_cfg_valid && (i_cfg_ratio < WIDTH'(MIN_RATIO));
  assign w_wr_ok  = i_cfg_valid && !w_wr_bad;

  clk_phase_ctr #(
    .WIDTH (WIDTH)
  ) u_phase (
    .i_clk   (i_ref_clk),
    .i_clr   (i_rst),
    .i_en    (r_clk_en),
    .i_ratio (r_div_ratio),
    .o_bnd_c (w_bnd)
  );

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      r_state      <= ST_OFF;
      r_div_ratio  <= WIDTH'(DEFAULT_RATIO);
      r_pend_ratio <= '0;
      r_pend_vld   <= 1'b0;
      r_clk_en     <= 1'b0;
      r_cfg_ack    <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_cfg_err <= w_wr_bad;
      r_cfg_ack <= 1'b0;

      // Divider idle: writes apply at once; running: defer to the next boundary
      if (r_state == ST_OFF) begin
        if (w_wr_ok) begin
          r_div_ratio <= i_cfg_ratio;
          r_cfg_ack   <= 1'b1;
        end
      end else if (w_bnd) begin
        if (w_wr_ok) begin
          r_div_ratio <= i_cfg_ratio;
          r_cfg_ack   <= 1'b1;
        end else if (r_pend_vld) begin
          r_div_ratio <= r_pend_ratio;
          r_cfg_ack   <= 1'b1;
        end
        r_pend_vld <= 1'b0;
      end else if (w_wr_ok) begin
        r_pend_ratio <= i_cfg_ratio;
        r_pend_vld   <= 1'b1;
      end

      case (r_state)
        ST_OFF: begin
          if (i_enable) begin
            r_state  <= ST_RUN;
            r_clk_en <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!i_enable) r_state <= ST_STOP;
        end
        ST_STOP: begin
          if (i_enable) begin
            r_state <= ST_RUN;
          end else if (w_bnd) begin
            r_state  <= ST_OFF;
            r_clk_en <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_OFF;
          r_clk_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLK_DIV_CTRL_TICK_EN
  logic r_period_tick;

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) r_period_tick <= 1'b0;
    else       r_period_tick <= w_bnd;
  end

  assign o_period_tick = r_period_tick;
`endif

  assign o_div_ratio = r_div_ratio;
  assign o_clk_en    = r_clk_en;
  assign o_cfg_ack   = r_cfg_ack;
  assign o_cfg_err   = r_cfg_err;
  assign o_busy      = r_pend_vld;

endmodule
